// File: rtl/store_byte_serializer.sv
// Store-side byte serializer: truncates a 32-bit store value to its access
// size and writes it little-endian, one byte per req/ack transfer, to a
// byte-wide data memory. Reports completion (Done) or rejection (Err).
module store_byte_serializer #(
  parameter int ADDR_W      = 32,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              Clk,
  input  logic              CLR,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       In,
  input  logic [1:0]        dataSize,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [7:0]        MemData,
  output logic              MemWE,
  input  logic              MemAck
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  logic [0:0]  state;
  logic [1:0]  k;        // index of the byte currently on the bus
  logic [1:0]  last;     // index of the final byte (N-1)
  logic [23:0] rest;     // captured bytes not yet placed on the bus
  logic [1:0]  req_last;
  logic        illegal;

  // Decode the incoming request: final byte index and legality.
  always_comb begin
    req_last = 2'd0;
    illegal  = 1'b0;
    case (dataSize)
      2'b00: req_last = 2'd0;
      2'b01: begin
        req_last = 2'd1;
        if (ALIGN_CHECK != 0 && Addr[0]) illegal = 1'b1;
      end
      2'b10: begin
        req_last = 2'd3;
        if (ALIGN_CHECK != 0 && Addr[1:0] != 2'b00) illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Busy and the write request are both just "in WRITE".
  assign Busy  = (state == WRITE);
  assign MemWE = (state == WRITE);

  // Transfer FSM; Done/Err are one-cycle registered pulses.
  always_ff @(posedge Clk or negedge CLR) begin
    if (!CLR) begin
      state   <= IDLE;
      k       <= 2'd0;
      last    <= 2'd0;
      rest    <= 24'd0;
      MemAddr <= '0;
      MemData <= 8'd0;
      Done    <= 1'b0;
      Err     <= 1'b0;
    end else begin
      Done <= 1'b0;
      Err  <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (illegal) begin
              Err <= 1'b1;
            end else begin
              state   <= WRITE;
              MemAddr <= Addr;
              MemData <= In[7:0];
              rest    <= In[31:8];
              k       <= 2'd0;
              last    <= req_last;
            end
          end
        end
        WRITE: begin
          if (MemAck) begin
            if (k == last) begin
              state   <= IDLE;
              MemData <= 8'd0;
              k       <= 2'd0;
              Done    <= 1'b1;
            end else begin
              // Next byte goes out back-to-back; address wraps naturally.
              k       <= k + 2'd1;
              MemAddr <= MemAddr + ADDR_W'(1);
              MemData <= rest[7:0];
              rest    <= {8'd0, rest[23:8]};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
